// File: rtl/vicii_sprite_mux_pkg.sv
// Shared VIC-II constants for the sprite mux and the register block:
// sprite count, colour-index width, collision/priority register addresses.
package vicii_sprite_mux_pkg;

  localparam int NUM_SPRITES = 8;
  localparam int COLOR_W     = 4;

  localparam logic [7:0] REG_SPR_PRIO = 8'h1B;
  localparam logic [7:0] REG_COLL_MM  = 8'h1E;
  localparam logic [7:0] REG_COLL_MD  = 8'h1F;

  typedef logic [COLOR_W-1:0]     color_t;
  typedef logic [NUM_SPRITES-1:0] sprMask_t;

  // True when two or more sprites are enabled on the same pixel.
  // Clearing the lowest set bit leaves something only if another bit was set.
  function automatic logic hasMultiple(input sprMask_t v);
    return (v & (v - sprMask_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/vicii_coll_reg.sv
// Collision register: accumulates hit bits between CPU reads, clears on the
// read strobe, and pulses an IRQ on the first hit after a clear.
module vicii_coll_reg
  import vicii_sprite_mux_pkg::*;
#(
  parameter int W = NUM_SPRITES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_i,
  input  logic [W-1:0] hit_i,
  output logic [W-1:0] reg_o,
  output logic         irq_o
);

  logic [W-1:0] collReg_q, collReg_d;
  logic [W-1:0] base;
  logic         irq_q, irq_d;

  // A read wipes the old bits, but the hits of that same cycle still land.
  always_comb begin
    base      = rd_i ? '0 : collReg_q;
    collReg_d = base | hit_i;
    irq_d     = (base == '0) && (hit_i != '0);
  end

  // State and IRQ pulse update together so the pulse lines up with the new bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      collReg_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      collReg_q <= collReg_d;
      irq_q     <= irq_d;
    end
  end

  assign reg_o = collReg_q;
  assign irq_o = irq_q;

endmodule

// File: rtl/vicii_sprite_mux.sv
// Final pixel mux: picks the highest-priority sprite against the background,
// and feeds the sprite-sprite and sprite-background collision registers.
module vicii_sprite_mux
  import vicii_sprite_mux_pkg::*;
#(
  // Only the eight-sprite configuration is meaningful for the VIC-II.
  parameter int NSPR = NUM_SPRITES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NSPR-1:0]         spr_en,
  input  logic [COLOR_W*NSPR-1:0] spr_pix,
  input  logic [COLOR_W-1:0]      bg_pix,
  input  logic                    bg_fg,
  input  logic                    disp_en,
  input  logic [NSPR-1:0]         MDP,
  input  logic                    rd_mm,
  input  logic                    rd_md,
  output logic [COLOR_W-1:0]      pix_out,
  output logic [NSPR-1:0]         MM,
  output logic [NSPR-1:0]         MD,
  output logic                    irq_mmc,
  output logic                    irq_mbc
);

  color_t          pixOut_q, pixOut_d;
  logic [NSPR-1:0] hitMm, hitMd;

  // Walk from the lowest priority upward so the last enabled sprite seen
  // (lowest index) decides; a winner hidden behind foreground shows the
  // background, never a lower-priority sprite underneath it.
  always_comb begin
    pixOut_d = bg_pix;
    for (int n = NSPR - 1; n >= 0; n--) begin
      if (spr_en[n]) begin
        pixOut_d = (MDP[n] && bg_fg) ? bg_pix : spr_pix[n*COLOR_W +: COLOR_W];
      end
    end
  end

  // Collisions only count inside the display window.
  always_comb begin
    hitMm = (disp_en && hasMultiple(spr_en)) ? spr_en : '0;
    hitMd = (disp_en && bg_fg) ? spr_en : '0;
  end

  // Resolved colour is registered, one pixel behind the inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixOut_q <= '0;
    end else begin
      pixOut_q <= pixOut_d;
    end
  end

  assign pix_out = pixOut_q;

  vicii_coll_reg #(.W(NSPR)) uCollMm (
    .clk   (clk),
    .reset (reset),
    .rd_i  (rd_mm),
    .hit_i (hitMm),
    .reg_o (MM),
    .irq_o (irq_mmc)
  );

  vicii_coll_reg #(.W(NSPR)) uCollMd (
    .clk   (clk),
    .reset (reset),
    .rd_i  (rd_md),
    .hit_i (hitMd),
    .reg_o (MD),
    .irq_o (irq_mbc)
  );

endmodule

// File: tb/tb_vicii_sprite_mux.sv
// Directed bench for vicii_sprite_mux with a behavioural model and an
// expected-result queue popped one clock after each pixel is driven.
module tb_vicii_sprite_mux;

  logic        clk;
  logic        reset;
  logic [7:0]  spr_en;
  logic [31:0] spr_pix;
  logic [3:0]  bg_pix;
  logic        bg_fg;
  logic        disp_en;
  logic [7:0]  MDP;
  logic        rd_mm;
  logic        rd_md;
  logic [3:0]  pix_out;
  logic [7:0]  MM;
  logic [7:0]  MD;
  logic        irq_mmc;
  logic        irq_mbc;

  typedef struct packed {
    logic [3:0] pix;
    logic [7:0] mm;
    logic [7:0] md;
    logic       irqMm;
    logic       irqMd;
  } expect_t;

  expect_t expQ[$];

  logic [7:0] modelMm;
  logic [7:0] modelMd;
  int         vectors;
  int         miscompares;

  // Colour palette: sprite1 = 2, sprite2 = 7, others distinct.
  localparam logic [31:0] PALETTE = 32'hBA95_4721;

  vicii_sprite_mux #(.NSPR(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .spr_en  (spr_en),
    .spr_pix (spr_pix),
    .bg_pix  (bg_pix),
    .bg_fg   (bg_fg),
    .disp_en (disp_en),
    .MDP     (MDP),
    .rd_mm   (rd_mm),
    .rd_md   (rd_md),
    .pix_out (pix_out),
    .MM      (MM),
    .MD      (MD),
    .irq_mmc (irq_mmc),
    .irq_mbc (irq_mbc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  // Drives the current pixel and pushes what the model says should appear.
  task automatic applyStimulus();
    expect_t e;
    int      cnt;
    logic [7:0] hitMm, hitMd, baseMm, baseMd;
    e.pix = bg_pix;
    for (int n = 0; n < 8; n++) begin
      if (spr_en[n]) begin
        e.pix = (MDP[n] && bg_fg) ? bg_pix : spr_pix[4*n +: 4];
        break;
      end
    end
    cnt = 0;
    for (int n = 0; n < 8; n++) cnt += int'(spr_en[n]);
    hitMm   = (cnt >= 2 && disp_en) ? spr_en : 8'h00;
    hitMd   = (bg_fg && disp_en) ? spr_en : 8'h00;
    baseMm  = rd_mm ? 8'h00 : modelMm;
    baseMd  = rd_md ? 8'h00 : modelMd;
    modelMm = baseMm | hitMm;
    modelMd = baseMd | hitMd;
    e.mm    = modelMm;
    e.md    = modelMd;
    e.irqMm = (baseMm == 8'h00) && (hitMm != 8'h00);
    e.irqMd = (baseMd == 8'h00) && (hitMd != 8'h00);
    expQ.push_back(e);
  endtask

  // Waits for the capturing edge, then compares every output to the model.
  task automatic checkOutput(input string tag);
    expect_t e;
    @(posedge clk);
    #1;
    rd_mm = 1'b0;
    rd_md = 1'b0;
    if (expQ.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s: observed empty queue expected an entry", tag);
    end else begin
      e = expQ.pop_front();
      check({tag, ".pix"},  {4'h0, pix_out}, {4'h0, e.pix});
      check({tag, ".MM"},   MM, e.mm);
      check({tag, ".MD"},   MD, e.md);
      check({tag, ".irqMm"}, {7'h0, irq_mmc}, {7'h0, e.irqMm});
      check({tag, ".irqMd"}, {7'h0, irq_mbc}, {7'h0, e.irqMd});
    end
  endtask

  task automatic step(input string tag);
    applyStimulus();
    checkOutput(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    modelMm     = 8'h00;
    modelMd     = 8'h00;
    reset       = 1'b0;
    spr_en      = 8'h00;
    spr_pix     = PALETTE;
    bg_pix      = 4'h0;
    bg_fg       = 1'b0;
    disp_en     = 1'b0;
    MDP         = 8'h00;
    rd_mm       = 1'b0;
    rd_md       = 1'b0;

    #12;
    check("rst.pix", {4'h0, pix_out}, 8'h00);
    check("rst.MM", MM, 8'h00);
    check("rst.MD", MD, 8'h00);
    reset = 1'b1;

    // Build MM = 05, then reset mid-cycle with a read strobe in flight.
    disp_en = 1'b1; spr_en = 8'h05;
    step("mm05");
    spr_en = 8'h00; rd_mm = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("asyncRst.pix", {4'h0, pix_out}, 8'h00);
    check("asyncRst.MM", MM, 8'h00);
    check("asyncRst.MD", MD, 8'h00);
    check("asyncRst.irq", {6'h0, irq_mmc, irq_mbc}, 8'h00);
    modelMm = 8'h00; modelMd = 8'h00;
    rd_mm = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Background only.
    bg_pix = 4'h6; disp_en = 1'b0;
    step("bgOnly");

    // Sprite priority and hidden winner.
    spr_en = 8'b0000_0110;
    step("prio");
    MDP = 8'h02; bg_fg = 1'b1; bg_pix = 4'hE;
    step("hidden");
    MDP = 8'h00; bg_fg = 1'b0;

    // Sprite-sprite collision held three pixels: one pulse only.
    disp_en = 1'b1; spr_en = 8'h81;
    step("ss1");
    step("ss2");
    step("ss3");

    // Read with no hit clears.
    spr_en = 8'h00; rd_mm = 1'b1;
    step("rdClr");

    // Outside display window: nothing counted.
    disp_en = 1'b0; spr_en = 8'h81;
    step("noDisp1");
    step("noDisp2");
    step("noDisp3");

    // Fresh collision after clear pulses again.
    disp_en = 1'b1; spr_en = 8'h03;
    step("ss03");

    // Rebuild 81, then read and hit on the same edge.
    spr_en = 8'h00; rd_mm = 1'b1;
    step("rdClr2");
    spr_en = 8'h81;
    step("ss81");
    spr_en = 8'h0C; rd_mm = 1'b1;
    step("rdHit");

    // Sprite-background collisions accumulate with one pulse.
    spr_en = 8'h10; bg_fg = 1'b1;
    step("sb10");
    spr_en = 8'h20;
    step("sb30");
    spr_en = 8'h00; rd_md = 1'b1;
    step("rdMd");

    // Pseudo-random pixels against the model.
    for (int i = 0; i < 40; i++) begin
      spr_en  = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      spr_pix = $urandom;
      bg_pix  = 4'($urandom_range(0, 15));
      bg_fg   = 1'($urandom_range(0, 1));
      disp_en = 1'($urandom_range(0, 1));
      MDP     = 8'($urandom_range(0, 255));
      rd_mm   = ($urandom_range(0, 7) == 0);
      rd_md   = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
